// File: rtl/mul4_fitness_evaluator.sv
// Drives stimulus vectors into a 16-lane bit-sliced 2x2 multiplier candidate and
// accumulates the number of output bits that match the golden product.
module mul4_fitness_evaluator #(
  parameter int unsigned NUM_VECTORS = 8,
  parameter logic [31:0] SEED_A      = 32'hACE12468,
  parameter logic [31:0] SEED_B      = 32'h1357BDF9,
  localparam int unsigned FIT_W      = $clog2(NUM_VECTORS*64+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [15:0]      a1,
  output logic [15:0]      a0,
  output logic [15:0]      b1,
  output logic [15:0]      b0,
  input  logic [15:0]      y3,
  input  logic [15:0]      y2,
  input  logic [15:0]      y1,
  input  logic [15:0]      y0,
  output logic             busy,
  output logic             done,
  output logic [FIT_W-1:0] fitness,
  output logic             perfect
);

  // state  | meaning
  // IDLE   | waiting for start, results held
  // RUN    | issuing one vector per cycle
  // DRAIN1 | last vector being scored
  // DRAIN2 | last score added, done pulses on exit
  typedef enum logic [1:0] {IDLE, RUN, DRAIN1, DRAIN2} state_t;

  localparam int unsigned CNT_W     = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [31:0] SEED_A_NZ = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
  localparam logic [31:0] SEED_B_NZ = (SEED_B == 32'd0) ? 32'd1 : SEED_B;
  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS - 1);
  localparam logic [FIT_W-1:0] FIT_MAX  = FIT_W'(NUM_VECTORS * 64);

  state_t           state, state_next;
  logic             load, issue, last_vec, finish;
  logic [CNT_W-1:0] vec_cnt;
  logic [31:0]      lfsr_a, lfsr_b;
  logic             vec_valid, score_valid;
  logic [6:0]       score_reg, match_cnt;
  logic [63:0]      golden, match;
  logic [FIT_W-1:0] fit_sum;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'd0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_vec) state_next = DRAIN1;
      DRAIN1:  state_next = DRAIN2;
      DRAIN2:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load     = (state == IDLE) && start;
    issue    = (state == RUN);
    last_vec = issue && (vec_cnt == LAST_VEC);
    finish   = (state == DRAIN2);
  end

  // Golden 2-bit x 2-bit product, bit-sliced across all 16 lanes
  always_comb begin
    golden[15:0]  = a0 & b0;
    golden[31:16] = (a1 & b0) ^ (a0 & b1);
    golden[47:32] = a1 & b1 & ~(a0 & b0);
    golden[63:48] = a1 & a0 & b1 & b0;
    match = ~({y3, y2, y1, y0} ^ golden);
    match_cnt = '0;
    for (int i = 0; i < 64; i++) match_cnt = match_cnt + 7'(match[i]);
  end

  assign fit_sum = fitness + FIT_W'(score_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      {a1, a0, b1, b0} <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fitness     <= '0;
      perfect     <= 1'b0;
      lfsr_a      <= SEED_A_NZ;
      lfsr_b      <= SEED_B_NZ;
      vec_cnt     <= '0;
      vec_valid   <= 1'b0;
      score_valid <= 1'b0;
      score_reg   <= '0;
    end else begin
      done        <= finish;
      busy        <= (state != IDLE) && !finish;
      vec_valid   <= issue;
      score_valid <= vec_valid;
      if (vec_valid) score_reg <= match_cnt;
      if (score_valid) fitness <= fit_sum;
      if (finish) perfect <= (fit_sum == FIT_MAX);
      if (issue) begin
        vec_cnt <= vec_cnt + CNT_W'(1);
        if (vec_cnt == '0) begin
          // lane i carries i[3:0] so every operand pair appears once
          a1 <= 16'hFF00;
          a0 <= 16'hF0F0;
          b1 <= 16'hCCCC;
          b0 <= 16'hAAAA;
        end else begin
          {a1, a0} <= lfsr_a;
          {b1, b0} <= lfsr_b;
          lfsr_a   <= lfsr_step(lfsr_a);
          lfsr_b   <= lfsr_step(lfsr_b);
        end
      end
      if (load) begin
        fitness <= '0;
        perfect <= 1'b0;
        lfsr_a  <= SEED_A_NZ;
        lfsr_b  <= SEED_B_NZ;
        vec_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mul4_fitness_evaluator.sv
// Directed bench for mul4_fitness_evaluator: one N=1 and one N=8 instance, each
// fed by a behavioural candidate model selected per test.
module tb_mul4_fitness_evaluator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start8 = 1'b0;
  int   mode1 = 0;
  int   checks = 0, errors = 0;

  logic [15:0] p1_a1, p1_a0, p1_b1, p1_b0, p1_y3, p1_y2, p1_y1, p1_y0;
  logic [15:0] p8_a1, p8_a0, p8_b1, p8_b0, p8_y3, p8_y2, p8_y1, p8_y0;
  logic        busy1, done1, perf1, busy8, done8, perf8;
  logic [6:0]  fit1;
  logic [9:0]  fit8;
  logic [63:0] y1cat, y8cat;

  always #5 clk = ~clk;

  function automatic logic [63:0] gold(input logic [15:0] a1, a0, b1, b0);
    logic [15:0] g3, g2, g1, g0;
    logic [3:0]  p;
    for (int i = 0; i < 16; i++) begin
      p = 4'({a1[i], a0[i]}) * 4'({b1[i], b0[i]});
      g3[i] = p[3]; g2[i] = p[2]; g1[i] = p[1]; g0[i] = p[0];
    end
    return {g3, g2, g1, g0};
  endfunction

  always_comb begin
    case (mode1)
      1:       y1cat = 64'd0;
      2:       y1cat = {64{1'b1}};
      3:       y1cat = gold(p1_a1, p1_a0, p1_b1, p1_b0) ^ 64'd1;
      default: y1cat = gold(p1_a1, p1_a0, p1_b1, p1_b0);
    endcase
    y8cat = gold(p8_a1, p8_a0, p8_b1, p8_b0);
  end
  assign {p1_y3, p1_y2, p1_y1, p1_y0} = y1cat;
  assign {p8_y3, p8_y2, p8_y1, p8_y0} = y8cat;

  mul4_fitness_evaluator #(.NUM_VECTORS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a1(p1_a1), .a0(p1_a0), .b1(p1_b1), .b0(p1_b0),
    .y3(p1_y3), .y2(p1_y2), .y1(p1_y1), .y0(p1_y0),
    .busy(busy1), .done(done1), .fitness(fit1), .perfect(perf1)
  );

  mul4_fitness_evaluator #(.NUM_VECTORS(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .a1(p8_a1), .a0(p8_a0), .b1(p8_b1), .b0(p8_b0),
    .y3(p8_y3), .y2(p8_y2), .y1(p8_y1), .y0(p8_y0),
    .busy(busy8), .done(done8), .fitness(fit8), .perfect(perf8)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({p1_a1, p1_a0, p1_b1, p1_b0, busy1, done1, fit1, perf1} !== '0) begin
      errors++;
      $display("FAIL reset_n1 got stim=%h busy=%b done=%b fit=%0d perf=%b want all zero",
               {p1_a1, p1_a0, p1_b1, p1_b0}, busy1, done1, fit1, perf1);
    end
    checks++;
    if ({p8_a1, p8_a0, p8_b1, p8_b0, busy8, done8, fit8, perf8} !== '0) begin
      errors++;
      $display("FAIL reset_n8 got stim=%h busy=%b done=%b fit=%0d perf=%b want all zero",
               {p8_a1, p8_a0, p8_b1, p8_b0}, busy8, done8, fit8, perf8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Start at edge 0; done expected at edge 3 with the given score.
  task automatic test_n1(input int mode, input int exp_fit, input logic exp_perf, input string name);
    @(negedge clk);
    mode1 = mode;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        checks++;
        if ({p1_a1, p1_a0, p1_b1, p1_b0} !== 64'hFF00_F0F0_CCCC_AAAA) begin
          errors++;
          $display("FAIL %s_vec0 got %h want ff00f0f0ccccaaaa", name, {p1_a1, p1_a0, p1_b1, p1_b0});
        end
      end
      checks++;
      if (done1 !== (e == 3)) begin
        errors++;
        $display("FAIL %s_done edge %0d got %b want %b", name, e, done1, (e == 3));
      end
      if (e == 3) begin
        checks++;
        if (fit1 !== 7'(exp_fit) || perf1 !== exp_perf || busy1 !== 1'b0) begin
          errors++;
          $display("FAIL %s_result got fit=%0d perf=%b busy=%b want fit=%0d perf=%b busy=0",
                   name, fit1, perf1, busy1, exp_fit, exp_perf);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    mode1 = 0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start1 = 1'b1;          // held into edge 3 (done edge) and edge 4
    @(posedge clk); #1;
    checks++;
    if (done1 !== 1'b1 || fit1 !== 7'd64) begin
      errors++;
      $display("FAIL b2b_first got done=%b fit=%0d want done=1 fit=64", done1, fit1);
    end
    @(negedge clk);
    @(posedge clk); #1;     // edge 4: restart accepted from the done cycle
    start1 = 1'b0;
    checks++;
    if (fit1 !== 7'd0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_clear got fit=%0d done=%b want fit=0 done=0", fit1, done1);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done1 !== 1'b1 || fit1 !== 7'd64 || perf1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got done=%b fit=%0d perf=%b want done=1 fit=64 perf=1",
               done1, fit1, perf1);
    end
  endtask

  // N=8 run; optional ignored restart pulse or mid-run reset at a given edge.
  task automatic test_n8(input int restart_at, input int rst_at, input string name);
    int done_cnt = 0;
    logic exp_busy;
    @(negedge clk);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (e == restart_at) start8 = 1'b1;
      if (e == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      rst = 1'b0;
      if (done8 === 1'b1) done_cnt++;
      exp_busy = (rst_at > 0) ? (e < rst_at) : (e <= 9);
      checks++;
      if (busy8 !== exp_busy) begin
        errors++;
        $display("FAIL %s_busy edge %0d got %b want %b", name, e, busy8, exp_busy);
      end
      if (e == 1) begin
        checks++;
        if ({p8_a1, p8_a0, p8_b1, p8_b0} !== 64'hFF00_F0F0_CCCC_AAAA) begin
          errors++;
          $display("FAIL %s_vec0 got %h want ff00f0f0ccccaaaa", name, {p8_a1, p8_a0, p8_b1, p8_b0});
        end
      end
      if (e == 2) begin
        checks++;
        if ({p8_a1, p8_a0, p8_b1, p8_b0} !== 64'hACE1_2468_1357_BDF9) begin
          errors++;
          $display("FAIL %s_vec1 got %h want ace124681357bdf9", name, {p8_a1, p8_a0, p8_b1, p8_b0});
        end
      end
      if (rst_at < 0) begin
        checks++;
        if (done8 !== (e == 10)) begin
          errors++;
          $display("FAIL %s_done edge %0d got %b want %b", name, e, done8, (e == 10));
        end
        if (e >= 10) begin
          checks++;
          if (fit8 !== 10'd512 || perf8 !== 1'b1) begin
            errors++;
            $display("FAIL %s_result edge %0d got fit=%0d perf=%b want fit=512 perf=1",
                     name, e, fit8, perf8);
          end
        end
      end else if (e == rst_at) begin
        checks++;
        if (fit8 !== 10'd0 || perf8 !== 1'b0 || {p8_a1, p8_a0, p8_b1, p8_b0} !== 64'd0) begin
          errors++;
          $display("FAIL %s_abort got fit=%0d perf=%b stim=%h want all zero",
                   name, fit8, perf8, {p8_a1, p8_a0, p8_b1, p8_b0});
        end
      end
    end
    checks++;
    if (done_cnt !== ((rst_at < 0) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_done_count got %0d want %0d", name, done_cnt, (rst_at < 0) ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_n1(0, 64, 1'b1, "n1_correct");
    test_n1(1, 50, 1'b0, "n1_zeros");
    test_n1(2, 14, 1'b0, "n1_ones");
    test_n1(3, 63, 1'b0, "n1_onebit");
    test_back_to_back();
    test_n8(-1, -1, "n8_basic");
    test_n8(4, -1, "n8_restart_ignored");
    test_n8(-1, 5, "n8_abort");
    test_n8(-1, -1, "n8_after_abort");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
